ex_div_unit: RTL
================

# ex_div_unit

Iterative radix-2 divider with its own sequencing FSM for the RV32M DIV/DIVU/REM/REMU instructions. It sits beside the ALU/multiplier in the EX stage. While a divide is in flight it stalls the front of the pipeline. On completion it presents the result for one cycle, and the EX/MEM register captures it through the result-select path. It also handles the architectural special cases: divide-by-zero and signed overflow.

## Interface
Parameters:
- XLEN, 32, operand/result width; iteration counter is $clog2(XLEN) bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  EX holds a divide instruction; held high by EX until the done cycle.
- div_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- src1  in  XLEN  dividend (post-forwarding).
- src2  in  XLEN  divisor (post-forwarding).
- flush  in  1  kill the in-flight divide (branch/jump redirect).
- stall_ex  out  1  hold IF/ID/EX; combinational: start & ~done.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse; result valid this cycle.
- result  out  XLEN  quotient or remainder, registered.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - flush=1 → stay IDLE, regardless of start.
  - start=1 → latch div_op and the operand sign flags.
  - Divisor==0 → DONE with quotient = all ones and remainder = src1.
  - DIV with src1 = 0x8000_0000 and src2 = 0xFFFF_FFFF → DONE with quotient 0x8000_0000 and remainder 0.
  - All other starts → load magnitudes (|x| only for DIV/REM), clear the partial remainder, counter=0 → CALC.
- CALC: one quotient bit per cycle, restoring.
  - Shift {rem,quo} left 1.
  - If rem ≥ divisor magnitude: rem -= divisor and set the quotient LSB.
  - counter increments; after the XLEN-th iteration (counter==XLEN-1) → DONE.
- DONE:
  - result is written on entry to DONE and held there; done=1.
  - Next state is always IDLE. start is not re-sampled in DONE, because EX advances in this cycle.
- Sign fix-up (signed ops only):
  - Quotient is negated if sign(src1) ≠ sign(src2).
  - Remainder takes the sign of src1.
- Output select: div_op[1]=0 → quotient, 1 → remainder.
- flush in CALC or DONE → IDLE next cycle. done is not asserted, and result keeps its previous value.
- Priority: rst > flush > normal sequencing.
- If start drops during CALC (not expected): the operation continues, done still pulses, and stall_ex stays 0.
- All arithmetic is XLEN-bit unsigned on the magnitudes. The subtract compare uses an XLEN+1-bit difference; the borrow bit decides the quotient bit.

## Timing
- Reset values: state=IDLE, result=0, done=0, busy=0, counter=0. stall_ex follows start while done=0.
- Normal divide, with start first sampled at edge 0 in IDLE:
  - CALC occupies cycles 1..XLEN.
  - DONE is cycle XLEN+1 (33 for XLEN=32).
  - stall_ex is high for XLEN+1 cycles and low in the DONE cycle.
- Special cases (divide-by-zero, signed overflow): DONE in cycle 1; stall_ex high for 1 cycle.
- Back-to-back divides: the second is accepted in the IDLE cycle right after DONE. Minimum spacing is XLEN+2 cycles start-to-start.
- busy is high from cycle 1 through the DONE cycle inclusive.
- Async rst mid-operation: all state clears immediately; no done pulse.

## Test plan
- DIV 100/7 → done at cycle 33, result=14. REM of the same operands → 2.
- DIV −7/2 (0xFFFF_FFF9, 2) → 0xFFFF_FFFD (−3). REM of the same → 0xFFFF_FFFF (−1). DIVU 0xFFFF_FFF9/2 → 0x7FFF_FFFC.
- DIVU 1234/0 → result 0xFFFF_FFFF, done at cycle 1. REMU 1234/0 → 1234.
- DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000 at cycle 1. REM of the same → 0.
- Flush asserted at cycle 10 of CALC:
  - Next cycle: busy=0, no done, result unchanged.
  - A new DIVU 9/3 starting the following cycle → 3 after 33 cycles.
- rst pulsed at cycle 5 of CALC → outputs at reset values immediately. A subsequent REMU 10/4 → 2, with correct latency.

Source files
------------

// File: rtl/ex_div_unit.sv
// ex_div_unit
//   Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, with its
//   own sequencing FSM. It stalls the front of the pipeline while a divide is
//   in flight, and it presents a registered result together with a one-cycle
//   done pulse.
//
// Ports
//   clk       clock
//   rst       asynchronous, active-high reset
//   start     EX holds a divide instruction (held until the done cycle)
//   div_op    00 DIV, 01 DIVU, 10 REM, 11 REMU
//   src1      dividend
//   src2      divisor
//   flush     kill the in-flight divide
//   stall_ex  hold IF/ID/EX (start & ~done)
//   busy      FSM not idle
//   done      one-cycle pulse, result valid
//   result    quotient or remainder, registered
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; special cases resolve directly to DONE
// CALC  | one restoring quotient bit per cycle, XLEN cycles
// DONE  | result valid, done=1; always returns to IDLE
module ex_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            stall_ex,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic            rem_sel;
  logic            q_neg;
  logic            r_neg;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [CW-1:0]   cnt;

  logic            is_signed;
  logic            s1_neg;
  logic            s2_neg;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            div_zero;
  logic            ovf;

  assign is_signed = ~div_op[0];
  assign s1_neg    = is_signed & src1[XLEN-1];
  assign s2_neg    = is_signed & src2[XLEN-1];
  assign mag1      = s1_neg ? -src1 : src1;
  assign mag2      = s2_neg ? -src2 : src2;
  assign div_zero  = (src2 == '0);
  assign ovf       = is_signed && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);

  // Restoring step. The shifted remainder is XLEN+1 bits wide; when its top
  // bit is set it certainly exceeds the divisor, and the low XLEN bits of the
  // difference are still exact because the true result is below the divisor.
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] res_nx;

  assign rem_sh = {rem, quo[XLEN-1]};
  assign diff   = {1'b0, rem_sh[XLEN-1:0]} - {1'b0, dvs};
  assign ge     = rem_sh[XLEN] | ~diff[XLEN];
  assign rem_nx = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx = {quo[XLEN-2:0], ge};
  assign q_fix  = q_neg ? -quo_nx : quo_nx;
  assign r_fix  = r_neg ? -rem_nx : rem_nx;
  assign res_nx = rem_sel ? r_fix : q_fix;

  assign stall_ex = start & ~done;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rem_sel <= 1'b0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dvs     <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      result  <= '0;
      done    <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rem_sel <= div_op[1];
            q_neg   <= s1_neg ^ s2_neg;
            r_neg   <= s1_neg;
            if (div_zero) begin
              result <= div_op[1] ? src1 : '1;
              done   <= 1'b1;
              state  <= DONE;
            end else if (ovf) begin
              // Quotient of the overflow case is the dividend itself.
              result <= div_op[1] ? '0 : src1;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              quo   <= mag1;
              dvs   <= mag2;
              rem   <= '0;
              cnt   <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) begin
            result <= res_nx;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
